// File: rtl/seq_divider.sv
// Sequential signed restoring divider: one quotient bit per clock, start/done handshake.
// State | meaning
// IDLE  | waiting for start; operands captured on acceptance
// DIV   | one restoring step per cycle, WIDTH cycles
// FIX   | apply signs and special-case overrides, register results
// DONE  | done pulse for one cycle, then back to IDLE
module seq_divider #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] R,
    output logic             busy,
    output logic             done,
    output logic             DivByZero,
    output logic             Overflow
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0]    COUNT_INIT = CW'(WIDTH - 1);
    localparam logic [WIDTH-1:0] MIN_INT    = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE,
        S_DIV,
        S_FIX,
        S_DONE
    } state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] rem, dvd, dvs;
    logic [CW-1:0]    count;
    logic             sign_q, sign_r, dz_pend, ovf_pend;
    logic [WIDTH-1:0] a_mag, b_mag;
    logic [WIDTH:0]   trial;

    // Magnitudes stay WIDTH-bit unsigned so |MIN_INT| = 2^(WIDTH-1) fits.
    assign a_mag = a[WIDTH-1] ? -a : a;
    assign b_mag = b[WIDTH-1] ? -b : b;
    assign trial = {rem, dvd[WIDTH-1]} - {1'b0, dvs};

    assign busy = (state == S_DIV) || (state == S_FIX);
    assign done = (state == S_DONE);

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (start) state_nxt = S_DIV;
            S_DIV:   if (count == '0) state_nxt = S_FIX;
            S_FIX:   state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rem       <= '0;
            dvd       <= '0;
            dvs       <= '0;
            count     <= '0;
            sign_q    <= 1'b0;
            sign_r    <= 1'b0;
            dz_pend   <= 1'b0;
            ovf_pend  <= 1'b0;
            Q         <= '0;
            R         <= '0;
            DivByZero <= 1'b0;
            Overflow  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        sign_q   <= a[WIDTH-1] ^ b[WIDTH-1];
                        sign_r   <= a[WIDTH-1];
                        dvd      <= a_mag;
                        dvs      <= b_mag;
                        rem      <= '0;
                        count    <= COUNT_INIT;
                        dz_pend  <= (b == '0);
                        ovf_pend <= (a == MIN_INT) && (b == '1);
                    end
                end
                S_DIV: begin
                    dvd   <= {dvd[WIDTH-2:0], ~trial[WIDTH]};
                    rem   <= trial[WIDTH] ? {rem[WIDTH-2:0], dvd[WIDTH-1]} : trial[WIDTH-1:0];
                    count <= count - CW'(1);
                end
                S_FIX: begin
                    // With a zero divisor every trial succeeds, so rem ends up as |a|.
                    if (dz_pend) begin
                        Q <= '1;
                        R <= sign_r ? -rem : rem;
                    end else if (ovf_pend) begin
                        Q <= MIN_INT;
                        R <= '0;
                    end else begin
                        Q <= sign_q ? -dvd : dvd;
                        R <= sign_r ? -rem : rem;
                    end
                    DivByZero <= dz_pend;
                    Overflow  <= ovf_pend;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_divider.sv
// Scoreboard bench for seq_divider: stimulus pushes expected results, a monitor checks each done.
module tb_seq_divider;

    localparam int W   = 32;
    localparam int LAT = W + 1;
    localparam int PERIOD = W + 3;
    localparam logic [W-1:0] MIN_INT = 32'h8000_0000;

    logic         clk, rst, start;
    logic [W-1:0] a, b, Q, R;
    logic         busy, done, DivByZero, Overflow;

    seq_divider #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
        .Q(Q), .R(R), .busy(busy), .done(done),
        .DivByZero(DivByZero), .Overflow(Overflow)
    );

    typedef struct {
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dz;
        logic         ovf;
        int           acc;
    } exp_t;

    exp_t scb[$];
    int cyc = 0, checks = 0, failures = 0, done_cnt = 0, n_expect = 0;

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    function automatic exp_t model(input logic [W-1:0] av, input logic [W-1:0] bv, input int acc);
        exp_t e;
        logic signed [W-1:0] sa, sd;
        sa = av;
        sd = bv;
        e.acc = acc;
        e.dz  = 1'b0;
        e.ovf = 1'b0;
        if (bv == '0) begin
            e.q  = '1;
            e.r  = av;
            e.dz = 1'b1;
        end else if (av == MIN_INT && bv == '1) begin
            e.q   = MIN_INT;
            e.r   = '0;
            e.ovf = 1'b1;
        end else begin
            e.q = sa / sd;
            e.r = sa % sd;
        end
        return e;
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (!rst && done) begin
            done_cnt++;
            chk("busy_with_done", {63'd0, busy}, 64'd0);
            if (scb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_done: done with empty scoreboard, Q=0x%0h R=0x%0h", Q, R);
            end else begin
                e = scb.pop_front();
                chk("quotient", {32'd0, Q}, {32'd0, e.q});
                chk("remainder", {32'd0, R}, {32'd0, e.r});
                chk("div_by_zero", {63'd0, DivByZero}, {63'd0, e.dz});
                chk("overflow", {63'd0, Overflow}, {63'd0, e.ovf});
                chk("latency", 64'(cyc - e.acc), 64'(LAT));
            end
        end
    end

    task automatic wait_idle();
        int n = 0;
        @(negedge clk);
        while ((busy || done) && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (busy || done) begin
            checks++;
            failures++;
            $display("FAIL wait_idle: busy=%0b done=%0b after 100 cycles, expected idle", busy, done);
        end
    endtask

    task automatic issue(input logic [W-1:0] av, input logic [W-1:0] bv);
        wait_idle();
        a     = av;
        b     = bv;
        start = 1'b1;
        scb.push_back(model(av, bv, cyc + 1));
        n_expect++;
        @(negedge clk);
        start = 1'b0;
        a     = $urandom;
        b     = $urandom;
    endtask

    function automatic logic [W-1:0] rand_op();
        case ($urandom_range(0, 9))
            0:       return '0;
            1:       return MIN_INT;
            2:       return '1;
            3:       return W'($urandom_range(0, 20));
            4:       return -W'($urandom_range(1, 20));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int acc0, k, dc, n;
        rst   = 1'b1;
        start = 1'b0;
        a     = '0;
        b     = '0;
        repeat (3) @(negedge clk);
        chk("rst_Q", {32'd0, Q}, 64'd0);
        chk("rst_R", {32'd0, R}, 64'd0);
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_done", {63'd0, done}, 64'd0);
        chk("rst_dz", {63'd0, DivByZero}, 64'd0);
        chk("rst_ovf", {63'd0, Overflow}, 64'd0);
        rst = 1'b0;

        issue(32'd100, 32'd7);
        issue(-32'd100, 32'd7);
        issue(32'd100, -32'd7);
        issue(-32'd100, -32'd7);
        issue(32'h7FFF_FFFF, 32'd1);
        issue(32'h8000_0000, 32'd2);
        issue(32'd5, 32'd7);
        issue(32'h8000_0000, 32'hFFFF_FFFF);
        issue(-32'd18, 32'd0);
        issue(32'd151, 32'd10);

        // start held high: accepted once per PERIOD cycles with the same operands
        wait_idle();
        a     = -32'd77;
        b     = 32'd5;
        start = 1'b1;
        acc0  = cyc + 1;
        for (int i = 0; i < 3; i++) begin
            scb.push_back(model(a, b, acc0 + i * PERIOD));
            n_expect++;
        end
        while (cyc < acc0 + 2 * PERIOD) @(negedge clk);
        start = 1'b0;

        // start pulse mid-operation must be ignored
        issue(32'd1000, 32'd7);
        repeat (5) @(negedge clk);
        start = 1'b1;
        a     = 32'd9;
        b     = 32'd2;
        @(negedge clk);
        start = 1'b0;

        // reset in the middle of a division discards it
        issue(32'd1000, 32'd3);
        k = cyc;
        while (cyc < k + 9) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_Q", {32'd0, Q}, 64'd0);
        chk("midrst_R", {32'd0, R}, 64'd0);
        chk("midrst_busy", {63'd0, busy}, 64'd0);
        chk("midrst_done", {63'd0, done}, 64'd0);
        chk("midrst_dz", {63'd0, DivByZero}, 64'd0);
        chk("midrst_ovf", {63'd0, Overflow}, 64'd0);
        scb.delete();
        n_expect--;
        dc = done_cnt;
        repeat (40) @(negedge clk);
        chk("no_done_after_rst", 64'(done_cnt), 64'(dc));

        // rst and start at the same edge: start is lost
        rst   = 1'b1;
        start = 1'b1;
        a     = 32'd10;
        b     = 32'd2;
        @(negedge clk);
        rst   = 1'b0;
        start = 1'b0;
        chk("rst_beats_start", {63'd0, busy}, 64'd0);

        issue(32'd1000, 32'd3);

        for (int i = 0; i < 1000; i++) issue(rand_op(), rand_op());

        n = 0;
        while (scb.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("scoreboard_drained", 64'(scb.size()), 64'd0);
        repeat (5) @(negedge clk);
        chk("done_count", 64'(done_cnt), 64'(n_expect));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
